lc3_datapath_gen: RTL

Parametrised successor to the lab-6 LC-3 datapath. It holds the PC, MAR, MDR, IR, NZP, BEN, LED registers and an 8-entry register file, all joined by one internal bus.
- Generalised to data width DW.
- Adds a multi-cycle shift-add multiplier with a start/busy/done handshake.
- Adds single-cycle shift ops.
- Adds a sticky bus-contention error flag.
Sits between the ISDU (control) and the memory/MIO interface, exactly where the existing datapath sits.

---
 rtl/lc3_datapath_gen_if.sv | 31 +++
 rtl/lc3_datapath_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lc3_datapath_gen_if.sv
// Control/status bundle between the ISDU/memory side and the LC-3 datapath.
// The master drives gates, loads and mux selects; the slave is the datapath.
interface lc3_datapath_gen_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned LEDW = 12
);
  logic            LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic            GatePC, GateMDR, GateALU, GateMARMUX;
  logic            ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN;
  logic [1:0]      PCMUX, ADDR2MUX;
  logic [2:0]      ALUK;
  logic            ALU_Start;
  logic [DW-1:0]   MDR_In;
  logic            ALU_Busy, ALU_Done, Bus_Err, BEN;
  logic [DW-1:0]   MAR, MDR, IR, PC;
  logic [LEDW-1:0] LED;

  modport master (
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, PCMUX, ADDR2MUX, ALUK, ALU_Start, MDR_In,
    input  ALU_Busy, ALU_Done, Bus_Err, BEN, MAR, MDR, IR, PC, LED
  );

  modport slave (
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, PCMUX, ADDR2MUX, ALUK, ALU_Start, MDR_In,
    output ALU_Busy, ALU_Done, Bus_Err, BEN, MAR, MDR, IR, PC, LED
  );
endinterface

// File: rtl/lc3_datapath_gen.sv
// Parametrised LC-3 datapath: architectural registers, register file and a single
// internal bus, plus shift ops, a shift-add multiplier and a sticky bus-contention flag.
module lc3_datapath_gen #(
  parameter int unsigned DW   = 16,
  parameter int unsigned LEDW = 12
) (
  input logic               Clk,
  input logic               Reset,
  lc3_datapath_gen_if.slave dp
);
  localparam int unsigned SW = $clog2(DW);

  logic [DW-1:0]   r_pc, r_mar, r_mdr, r_ir;
  logic [2:0]      r_nzp;
  logic            r_ben;
  logic [LEDW-1:0] r_led;
  logic [DW-1:0]   r_rf [8];
  logic            r_bus_err, r_busy, r_done;
  logic [DW-1:0]   r_prod, r_acc, r_mul_a, r_mul_b;
  logic [SW-1:0]   r_cnt;

  logic [DW-1:0] w_bus, w_sr1, w_sr2, w_alu_b, w_alu;
  logic [DW-1:0] w_imm5, w_off6, w_off9, w_off11;
  logic [DW-1:0] w_addr1, w_addr2, w_adder, w_pc_next, w_mdr_next, w_acc_next;
  logic [2:0]    w_dr, w_sr1_sel, w_gate_cnt;
  logic [SW-1:0] w_sh;
  logic          w_mul_start;

  assign w_imm5  = {{(DW-5){r_ir[4]}}, r_ir[4:0]};
  assign w_off6  = {{(DW-6){r_ir[5]}}, r_ir[5:0]};
  assign w_off9  = {{(DW-9){r_ir[8]}}, r_ir[8:0]};
  assign w_off11 = {{(DW-11){r_ir[10]}}, r_ir[10:0]};

  assign w_dr      = dp.DRMUX ? 3'd7 : r_ir[11:9];
  assign w_sr1_sel = dp.SR1MUX ? r_ir[11:9] : r_ir[8:6];
  assign w_sr1     = r_rf[w_sr1_sel];
  assign w_sr2     = r_rf[r_ir[2:0]];
  assign w_alu_b   = dp.SR2MUX ? w_imm5 : w_sr2;
  assign w_sh      = w_alu_b[SW-1:0];

  assign w_addr1 = dp.ADDR1MUX ? r_pc : w_sr1;
  always_comb begin
    w_addr2 = '0;
    case (dp.ADDR2MUX)
      2'b00:   w_addr2 = '0;
      2'b01:   w_addr2 = w_off6;
      2'b10:   w_addr2 = w_off9;
      default: w_addr2 = w_off11;
    endcase
  end
  assign w_adder = w_addr1 + w_addr2;

  always_comb begin
    w_alu = '0;
    case (dp.ALUK)
      3'b000:  w_alu = w_sr1 + w_alu_b;
      3'b001:  w_alu = w_sr1 & w_alu_b;
      3'b010:  w_alu = ~w_sr1;
      3'b011:  w_alu = w_sr1;
      3'b100:  w_alu = r_prod;
      3'b101:  w_alu = w_sr1 << w_sh;
      3'b110:  w_alu = w_sr1 >> w_sh;
      default: w_alu = $unsigned($signed(w_sr1) >>> w_sh);
    endcase
  end

  always_comb begin
    w_bus = '0;
    if (dp.GatePC)          w_bus = r_pc;
    else if (dp.GateMDR)    w_bus = r_mdr;
    else if (dp.GateALU)    w_bus = w_alu;
    else if (dp.GateMARMUX) w_bus = w_adder;
  end
  assign w_gate_cnt = {2'b00, dp.GatePC} + {2'b00, dp.GateMDR} + {2'b00, dp.GateALU}
                    + {2'b00, dp.GateMARMUX};

  always_comb begin
    w_pc_next = r_pc;
    case (dp.PCMUX)
      2'b00:   w_pc_next = r_pc + DW'(1);
      2'b01:   w_pc_next = w_adder;
      2'b10:   w_pc_next = w_bus;
      default: w_pc_next = r_pc;
    endcase
  end
  assign w_mdr_next = dp.MIO_EN ? dp.MDR_In : w_bus;

  assign w_mul_start = dp.ALU_Start && (dp.ALUK == 3'b100) && !r_busy;
  assign w_acc_next  = r_acc + (r_mul_b[0] ? r_mul_a : '0);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_pc      <= '0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_ir      <= '0;
      r_led     <= '0;
      r_nzp     <= 3'b010;
      r_ben     <= 1'b0;
      r_bus_err <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_prod    <= '0;
      r_acc     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (dp.LD_PC)  r_pc  <= w_pc_next;
      if (dp.LD_MAR) r_mar <= w_bus;
      if (dp.LD_MDR) r_mdr <= w_mdr_next;
      if (dp.LD_IR)  r_ir  <= w_bus;
      if (dp.LD_LED) r_led <= r_ir[LEDW-1:0];
      if (dp.LD_REG) r_rf[w_dr] <= w_bus;
      // BEN sees the condition codes held before this edge's LD_CC.
      if (dp.LD_BEN) r_ben <= |(r_ir[11:9] & r_nzp);
      if (dp.LD_CC) begin
        if (w_bus[DW-1])    r_nzp <= 3'b100;
        else if (w_bus == '0) r_nzp <= 3'b010;
        else                r_nzp <= 3'b001;
      end
      if (w_gate_cnt > 3'd1) r_bus_err <= 1'b1;

      // One multiplier bit per busy cycle; the last one publishes the product.
      if (r_busy) begin
        r_acc   <= w_acc_next;
        r_mul_a <= r_mul_a << 1;
        r_mul_b <= r_mul_b >> 1;
        r_cnt   <= r_cnt + SW'(1);
        if (r_cnt == SW'(DW - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_prod <= w_acc_next;
        end
      end else if (w_mul_start) begin
        r_acc   <= '0;
        r_mul_a <= w_sr1;
        r_mul_b <= w_alu_b;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
    end
  end

  assign dp.PC       = r_pc;
  assign dp.MAR      = r_mar;
  assign dp.MDR      = r_mdr;
  assign dp.IR       = r_ir;
  assign dp.LED      = r_led;
  assign dp.BEN      = r_ben;
  assign dp.Bus_Err  = r_bus_err;
  assign dp.ALU_Busy = r_busy;
  assign dp.ALU_Done = r_done;
endmodule
